// File: rtl/ysyx_24080014_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encodings,
// bus response codes and the default reset vector.
package ysyx_24080014_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4
    } state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ysyx_24080014_fetch_ctrl.sv
// Multi-cycle fetch sequencer: one imem read per instruction, hands the word
// to decode, waits for writeback, then advances the PC and pulses commit.
module ysyx_24080014_fetch_ctrl
    import ysyx_24080014_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 1024,
    parameter int          TO_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic        pc_we,
    output logic [31:0] next_pc_o,
    output logic        commit_o,
    output logic        imem_arvalid,
    input  logic        imem_arready,
    output logic [31:0] imem_araddr,
    input  logic        imem_rvalid,
    output logic        imem_rready,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_fault,
    input  logic        wb_done,
    input  logic        wb_redirect,
    input  logic [31:0] wb_target,
    output logic        timeout_o
);

    localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(TIMEOUT);

    state_e          state_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            inst_valid_q;
    logic            fault_q;
    logic            first_q;
    logic [31:0]     inst_q;
    logic [31:0]     inst_pc_q;
    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic            commit;

    assign commit = (state_q == S_EXEC) && wb_done;

    // Bus-wait counter: runs through AR and R, saturates, zero elsewhere.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_AR || (state_q == S_R && !imem_rvalid))
            cnt_d = (cnt_q == TIMEOUT_CNT) ? cnt_q : cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                S_IDLE: begin
                    state_q   <= S_AR;
                    arvalid_q <= 1'b1;
                end
                S_AR: begin
                    if (imem_arready) begin
                        state_q   <= S_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                S_R: begin
                    if (imem_rvalid) begin
                        state_q      <= S_ISSUE;
                        rready_q     <= 1'b0;
                        inst_valid_q <= 1'b1;
                        inst_q       <= imem_rdata;
                        inst_pc_q    <= pc_i;
                        fault_q      <= (imem_rresp != RESP_OKAY);
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        state_q      <= S_EXEC;
                        inst_valid_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (wb_done) begin
                        state_q   <= S_AR;
                        arvalid_q <= 1'b1;
                        first_q   <= 1'b0;
                        // The first retirement after reset must come from the reset vector.
                        if (first_q)
                            assert (inst_pc_q == RESET_PC);
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_arvalid = arvalid_q;
    assign imem_araddr  = pc_i;
    assign imem_rready  = rready_q;
    assign inst_valid   = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_fault   = fault_q;
    assign timeout_o    = (cnt_q == TIMEOUT_CNT);
    assign pc_we        = commit;
    assign commit_o     = commit;
    assign next_pc_o    = (commit && wb_redirect) ? word_align(wb_target) : pc_i + 32'd4;

endmodule

// File: tb/tb_ysyx_24080014_fetch_ctrl.sv
// Scoreboard bench for the fetch sequencer: directed fetches push expected
// AR addresses, issued instructions and commits; a negedge monitor checks them.
module tb_ysyx_24080014_fetch_ctrl;

    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } inst_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_q;
    logic        pc_we, commit_o, imem_arvalid, imem_rready, inst_valid, inst_fault, timeout_o;
    logic [31:0] next_pc_o, imem_araddr, inst_o, inst_pc_o;
    logic        imem_arready = 1'b0, imem_rvalid = 1'b0, inst_ready = 1'b0;
    logic        wb_done = 1'b0, wb_redirect = 1'b0;
    logic [31:0] imem_rdata = '0, wb_target = '0;
    logic [1:0]  imem_rresp = 2'b00;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_commit = 0;
    int          cyc = 0;
    logic [31:0] exp_ar[$];
    inst_t       exp_inst[$];
    logic [31:0] exp_commit[$];
    int          commit_cyc[$];
    inst_t       mon_inst;
    logic [31:0] mon_pc;

    ysyx_24080014_fetch_ctrl #(
        .RESET_PC(32'h8000_0000),
        .TIMEOUT (TIMEOUT),
        .TO_W    (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_q),
        .pc_we       (pc_we),
        .next_pc_o   (next_pc_o),
        .commit_o    (commit_o),
        .imem_arvalid(imem_arvalid),
        .imem_arready(imem_arready),
        .imem_araddr (imem_araddr),
        .imem_rvalid (imem_rvalid),
        .imem_rready (imem_rready),
        .imem_rdata  (imem_rdata),
        .imem_rresp  (imem_rresp),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_o      (inst_o),
        .inst_pc_o   (inst_pc_o),
        .inst_fault  (inst_fault),
        .wb_done     (wb_done),
        .wb_redirect (wb_redirect),
        .wb_target   (wb_target),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PC register model sharing the same reset.
    always @(posedge clk) begin
        if (!rst)
            pc_q <= 32'h8000_0000;
        else if (pc_we)
            pc_q <= next_pc_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with no expected entry", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every handshake/commit against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            if (imem_arvalid && imem_arready) begin
                if (exp_ar.size() == 0) note_fail("ar_unexpected");
                else check("araddr", imem_araddr, exp_ar.pop_front());
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst.size() == 0) note_fail("inst_unexpected");
                else begin
                    mon_inst = exp_inst.pop_front();
                    check("inst_o", inst_o, mon_inst.inst);
                    check("inst_pc_o", inst_pc_o, mon_inst.pc);
                    check("inst_fault", {31'd0, inst_fault}, {31'd0, mon_inst.fault});
                end
            end
            if (commit_o || pc_we) begin
                n_commit++;
                commit_cyc.push_back(cyc);
                if (exp_commit.size() == 0) note_fail("commit_unexpected");
                else begin
                    mon_pc = exp_commit.pop_front();
                    $display("commit #%0d: pc=0x%08h next_pc=0x%08h", n_commit, pc_q, next_pc_o);
                    check("next_pc_o", next_pc_o, mon_pc);
                    check("pc_we", {31'd0, pc_we}, 32'd1);
                    check("commit_o", {31'd0, commit_o}, 32'd1);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_pc_we", {31'd0, pc_we}, 32'd0);
        check("rst_commit", {31'd0, commit_o}, 32'd0);
        check("rst_arvalid", {31'd0, imem_arvalid}, 32'd0);
        check("rst_rready", {31'd0, imem_rready}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_fault", {31'd0, inst_fault}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("rst_inst_o", inst_o, 32'd0);
        check("rst_inst_pc_o", inst_pc_o, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        check_reset_outputs();
        rst = 1'b1;
    endtask

    // stop: 0 = complete instruction, 1 = reset while in S_R, 2 = reset while in S_ISSUE
    task automatic fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                         input logic [1:0] resp, input logic [31:0] data,
                         input logic redir, input logic [31:0] tgt,
                         input logic [31:0] nxt, input int stop);
        int n;
        int idx;
        exp_ar.push_back(addr);
        if (stop == 0) begin
            exp_inst.push_back('{inst: data, pc: addr, fault: (resp != 2'b00)});
            exp_commit.push_back(nxt);
        end
        n = 0;
        while (!imem_arvalid && n < 20) begin
            step();
            n++;
        end
        check("arvalid_seen", {31'd0, imem_arvalid}, 32'd1);
        idx = 0;
        for (int k = 0; k < ar_wait; k++) begin
            check("ar_hold_valid", {31'd0, imem_arvalid}, 32'd1);
            check("ar_hold_addr", imem_araddr, addr);
            check("rready_in_ar", {31'd0, imem_rready}, 32'd0);
            check("timeout_ar", {31'd0, timeout_o}, (idx >= TIMEOUT) ? 32'd1 : 32'd0);
            step();
            idx++;
        end
        imem_arready = 1'b1;
        check("timeout_ar", {31'd0, timeout_o}, (idx >= TIMEOUT) ? 32'd1 : 32'd0);
        step();
        idx++;
        imem_arready = 1'b0;
        if (stop == 1) begin
            check("rready_before_rst", {31'd0, imem_rready}, 32'd1);
            do_reset();
            return;
        end
        for (int k = 0; k <= r_wait; k++) begin
            if (k == r_wait) begin
                imem_rvalid = 1'b1;
                imem_rdata  = data;
                imem_rresp  = resp;
            end
            check("rready_in_r", {31'd0, imem_rready}, 32'd1);
            check("timeout_r", {31'd0, timeout_o}, (idx >= TIMEOUT) ? 32'd1 : 32'd0);
            step();
            idx++;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_rresp  = 2'b00;
        check("timeout_clear", {31'd0, timeout_o}, 32'd0);
        if (stop == 2) begin
            check("issue_valid", {31'd0, inst_valid}, 32'd1);
            check("issue_inst", inst_o, data);
            do_reset();
            return;
        end
        inst_ready = 1'b1;
        step();
        inst_ready  = 1'b0;
        wb_done     = 1'b1;
        wb_redirect = redir;
        wb_target   = tgt;
        step();
        wb_done     = 1'b0;
        wb_redirect = 1'b0;
        wb_target   = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, %0d commits seen", n_commit);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) step();
        check_reset_outputs();
        rst = 1'b1;

        // Zero-wait sequential run from the reset vector.
        fetch(32'h8000_0000, 0, 0, 2'b00, 32'h0000_0013, 1'b0, 32'h0, 32'h8000_0004, 0);
        fetch(32'h8000_0004, 0, 0, 2'b00, 32'h0010_0093, 1'b0, 32'h0, 32'h8000_0008, 0);
        fetch(32'h8000_0008, 0, 0, 2'b00, 32'h0020_0113, 1'b0, 32'h0, 32'h8000_000C, 0);
        fetch(32'h8000_000C, 0, 0, 2'b00, 32'h0030_0193, 1'b0, 32'h0, 32'h8000_0010, 0);
        if (commit_cyc.size() < 4) note_fail("commit_count_seq");
        else for (int i = 0; i < 3; i++)
            check("commit_spacing", commit_cyc[i+1] - commit_cyc[i], 32'd4);

        // Delayed arready, then a redirect to a misaligned target.
        fetch(32'h8000_0010, 3, 0, 2'b00, 32'h0040_0213, 1'b1, 32'h8000_0102, 32'h8000_0100, 0);
        // Faulting fetch still issues, then redirects.
        fetch(32'h8000_0100, 0, 0, 2'b10, 32'hDEAD_BEEF, 1'b1, 32'h8000_0004, 32'h8000_0004, 0);
        // Withheld rvalid drives the timeout flag.
        fetch(32'h8000_0004, 0, TIMEOUT + 5, 2'b00, 32'h0010_0093, 1'b0, 32'h0, 32'h8000_0008, 0);
        // PC wrap at the top of the address space.
        fetch(32'h8000_0008, 0, 0, 2'b00, 32'h0020_0113, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0);
        fetch(32'hFFFF_FFFC, 0, 0, 2'b00, 32'h0000_0513, 1'b0, 32'h0, 32'h0000_0000, 0);
        fetch(32'h0000_0000, 1, 2, 2'b00, 32'h0000_006F, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);

        // Reset in S_R, restart at the reset vector.
        fetch(32'h8000_0000, 0, 0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1);
        fetch(32'h8000_0000, 0, 0, 2'b00, 32'h0000_0093, 1'b0, 32'h0, 32'h8000_0004, 0);
        // Reset in S_ISSUE, restart at the reset vector.
        fetch(32'h8000_0004, 0, 0, 2'b00, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 2);
        fetch(32'h8000_0000, 0, 0, 2'b00, 32'h0000_0013, 1'b0, 32'h0, 32'h8000_0004, 0);

        step();
        check("ar_drained", exp_ar.size(), 32'd0);
        check("inst_drained", exp_inst.size(), 32'd0);
        check("commit_drained", exp_commit.size(), 32'd0);
        check("pc_we_count", n_commit, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
